regfile_wb_sink: RTL and testbench

Architectural register file that receives the writeback bundle (write data, destination register, write enable) produced at the end of the MIPS pipeline and serves the decode stage's two read ports. Same-cycle write-to-read bypass guarantees the ID stage sees a value being written back in that cycle. A handshaked dump port streams all registers out in index order for debug and testbench checking, without stalling the pipeline.

---
 rtl/regfile_wb_sink_if.sv | 33 +++
 rtl/regfile_wb_sink.sv | 120 ++++++++++++
 tb/tb_regfile_wb_sink.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sink_if.sv
// Writeback, decode-read and debug-dump signals of the architectural register file.
// master = pipeline/debug side, slave = register file.
interface regfile_wb_sink_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic              DumpStart;
    logic              DumpValid;
    logic              DumpReady;
    logic [ADDR_W-1:0] DumpIndex;
    logic [WIDTH-1:0]  DumpData;
    logic              DumpBusy;
    logic              DumpDone;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
               DumpStart, DumpReady,
        input  ReadData1, ReadData2, DumpValid, DumpIndex, DumpData, DumpBusy, DumpDone
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
               DumpStart, DumpReady,
        output ReadData1, ReadData2, DumpValid, DumpIndex, DumpData, DumpBusy, DumpDone
    );
endinterface

// File: rtl/regfile_wb_sink.sv
// MIPS architectural register file: writeback sink, two bypassed decode read ports,
// and a handshaked dump stream of all registers in index order.
module regfile_wb_sink #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                Clk,
    input  logic                Reset_n,
    regfile_wb_sink_if.slave    bus
);
    localparam int unsigned N_RD = 3;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [ADDR_W-1:0] r_idx, w_idx_nxt;
    logic [WIDTH-1:0]  r_dump_data, w_dump_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_done, w_done_nxt;
    logic              w_we;
    logic [ADDR_W-1:0] w_raddr [N_RD];
    logic [WIDTH-1:0]  w_rdata [N_RD];

    assign w_we = bus.RegWrite && (bus.WriteRegister != '0);

    // Port 2 is the dump's look-ahead read of the next index.
    always_comb begin
        w_raddr[0] = bus.ReadRegister1;
        w_raddr[1] = bus.ReadRegister2;
        w_raddr[2] = r_idx + ADDR_W'(1);
    end

    // r0 is hardwired zero; an in-flight writeback wins over storage.
    always_comb begin
        for (int k = 0; k < int'(N_RD); k++) begin
            if (w_raddr[k] == '0) begin
                w_rdata[k] = '0;
            end else if (bus.RegWrite && (bus.WriteRegister == w_raddr[k])) begin
                w_rdata[k] = bus.WriteData;
            end else begin
                w_rdata[k] = r_regs[w_raddr[k]];
            end
        end
    end

    assign bus.ReadData1 = w_rdata[0];
    assign bus.ReadData2 = w_rdata[1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_we) begin
            r_regs[bus.WriteRegister] <= bus.WriteData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_dump_data <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_dump_data <= w_dump_data_nxt;
            r_valid     <= w_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_dump_data_nxt = r_dump_data;
        unique case (r_state)
            S_IDLE: begin
                if (bus.DumpStart) begin
                    w_state_nxt     = S_SEND;
                    w_idx_nxt       = '0;
                    w_dump_data_nxt = '0;
                end
            end
            S_SEND: begin
                if (bus.DumpReady) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt       = w_raddr[2];
                        w_dump_data_nxt = w_rdata[2];
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_valid_nxt = (w_state_nxt == S_SEND);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    assign bus.DumpValid = r_valid;
    assign bus.DumpBusy  = r_valid;
    assign bus.DumpDone  = r_done;
    assign bus.DumpIndex = r_idx;
    assign bus.DumpData  = r_dump_data;
endmodule

// File: tb/tb_regfile_wb_sink.sv
// Scoreboard bench for regfile_wb_sink: a reference model pushes expected dump beats,
// a monitor checks reads every cycle and pops beats as they are accepted.
module tb_regfile_wb_sink;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic Clk;
    logic Reset_n;

    regfile_wb_sink_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    regfile_wb_sink #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          mon_en = 1'b0;

    // Reference model state
    logic [31:0] ref_regs [32];
    beat_t       exp_q [$];
    bit          m_active = 1'b0;
    int          m_idx = 0;
    bit          m_done = 1'b0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register semantics: r0 is zero, a write happening this cycle is visible, else stored value.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.RegWrite === 1'b1 && bus.WriteRegister == a) return bus.WriteData;
        return ref_regs[a];
    endfunction

    // Reference model: registers as an array, dump as "next index to send" plus a beat queue.
    initial begin
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) begin
                for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
                m_active = 1'b0;
                m_idx    = 0;
                m_done   = 1'b0;
                exp_q.delete();
            end else begin
                if (bus.RegWrite && bus.WriteRegister != 5'd0)
                    ref_regs[bus.WriteRegister] = bus.WriteData;
                if (m_done) begin
                    m_done = 1'b0;
                end else if (m_active) begin
                    if (bus.DumpReady) begin
                        if (m_idx == 31) begin
                            m_active = 1'b0;
                            m_done   = 1'b1;
                        end else begin
                            m_idx = m_idx + 1;
                            exp_q.push_back('{idx: 5'(m_idx), data: ref_regs[m_idx]});
                        end
                    end
                end else if (bus.DumpStart) begin
                    m_active = 1'b1;
                    m_idx    = 0;
                    exp_q.push_back('{idx: 5'd0, data: 32'd0});
                end
            end
        end
    end

    // Monitor: compares reads and the presented dump beat away from the active edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                check("rd1", 64'(bus.ReadData1), 64'(ref_read(bus.ReadRegister1)));
                check("rd2", 64'(bus.ReadData2), 64'(ref_read(bus.ReadRegister2)));
                check("dump_valid", 64'(bus.DumpValid), 64'(m_active));
                check("dump_busy", 64'(bus.DumpBusy), 64'(m_active));
                check("dump_done", 64'(bus.DumpDone), 64'(m_done));
                if (bus.DumpValid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL beat_unexpected: got idx %0d data 0x%0h, expected no beat",
                                 bus.DumpIndex, bus.DumpData);
                    end else begin
                        check("beat_idx", 64'(bus.DumpIndex), 64'(exp_q[0].idx));
                        check("beat_data", 64'(bus.DumpData), 64'(exp_q[0].data));
                        if (bus.DumpReady) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = a;
        bus.WriteData     = d;
        tick();
        bus.RegWrite = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge Clk);
            if (bus.DumpDone) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check(nm, 64'(seen), 64'd1);
        tick();
    endtask

    task automatic backpressure(input bit wr4, input logic [31:0] exp3, input logic [31:0] exp4);
        bit found = 1'b0;
        bus.DumpReady = 1'b1;
        bus.DumpStart = 1'b1;
        tick();
        bus.DumpStart = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (bus.DumpValid && bus.DumpIndex == 5'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("bp_reach_beat2", 64'(found), 64'd1);
        tick();
        bus.DumpReady     = 1'b0;
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd3;
        bus.WriteData     = 32'h0000_FFFF;
        for (int h = 0; h < 4; h++) begin
            @(negedge Clk);
            check("bp_hold_idx", 64'(bus.DumpIndex), 64'd3);
            check("bp_hold_data", 64'(bus.DumpData), 64'(exp3));
            tick();
            bus.RegWrite = 1'b0;
        end
        bus.DumpReady = 1'b1;
        if (wr4) begin
            bus.RegWrite      = 1'b1;
            bus.WriteRegister = 5'd4;
            bus.WriteData     = 32'h0000_AAAA;
        end
        tick();
        bus.RegWrite = 1'b0;
        @(negedge Clk);
        check("bp_beat4_idx", 64'(bus.DumpIndex), 64'd4);
        check("bp_beat4_data", 64'(bus.DumpData), 64'(exp4));
        tick();
        wait_done("bp_done_seen");
    endtask

    initial begin
        int cnt;
        bit got;
        Reset_n           = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        bus.DumpStart     = 1'b0;
        bus.DumpReady     = 1'b0;
        repeat (3) tick();
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        // Reset state
        for (int i = 0; i < 32; i++) begin
            bus.ReadRegister1 = 5'(i);
            bus.ReadRegister2 = 5'(31 - i);
            @(negedge Clk);
            check("reset_rd1", 64'(bus.ReadData1), 64'd0);
            check("reset_rd2", 64'(bus.ReadData2), 64'd0);
            tick();
        end
        check("reset_valid", 64'(bus.DumpValid), 64'd0);
        check("reset_done", 64'(bus.DumpDone), 64'd0);
        check("reset_index", 64'(bus.DumpIndex), 64'd0);
        check("reset_data", 64'(bus.DumpData), 64'd0);

        // Write/read and r0 discard
        wr(5'd5, 32'hDEAD_BEEF);
        bus.ReadRegister1 = 5'd5;
        @(negedge Clk);
        check("read_r5", 64'(bus.ReadData1), 64'hDEAD_BEEF);
        tick();
        wr(5'd0, 32'h0000_1234);
        bus.ReadRegister1 = 5'd0;
        @(negedge Clk);
        check("read_r0", 64'(bus.ReadData1), 64'd0);
        tick();

        // Same-cycle bypass on both ports
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd7;
        bus.WriteData     = 32'hCAFE_0007;
        bus.ReadRegister1 = 5'd7;
        bus.ReadRegister2 = 5'd7;
        @(negedge Clk);
        check("bypass_rd1", 64'(bus.ReadData1), 64'hCAFE_0007);
        check("bypass_rd2", 64'(bus.ReadData2), 64'hCAFE_0007);
        tick();
        bus.RegWrite = 1'b0;

        for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));

        // Full dump, DumpReady held high
        bus.DumpReady = 1'b1;
        bus.DumpStart = 1'b1;
        tick();
        bus.DumpStart = 1'b0;
        cnt = 1;
        got = 1'b0;
        while (cnt < 80) begin
            @(negedge Clk);
            if (bus.DumpDone) begin
                got = 1'b1;
                break;
            end
            tick();
            cnt++;
        end
        check("full_done_seen", 64'(got), 64'd1);
        check("full_done_latency", 64'(cnt), 64'd33);
        tick();

        backpressure(1'b0, 32'h0000_0103, 32'h0000_0104);
        backpressure(1'b1, 32'h0000_FFFF, 32'h0000_AAAA);

        // Mid-dump reset
        bus.DumpReady = 1'b1;
        bus.DumpStart = 1'b1;
        tick();
        bus.DumpStart = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (bus.DumpValid && bus.DumpIndex == 5'd10) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("mid_reach_beat10", 64'(got), 64'd1);
        tick();
        Reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.DumpValid), 64'd0);
        check("mid_rst_done", 64'(bus.DumpDone), 64'd0);
        check("mid_rst_index", 64'(bus.DumpIndex), 64'd0);
        check("mid_rst_data", 64'(bus.DumpData), 64'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        repeat (3) tick();
        bus.DumpStart = 1'b1;
        tick();
        bus.DumpStart = 1'b0;
        @(negedge Clk);
        check("restart_valid", 64'(bus.DumpValid), 64'd1);
        check("restart_index", 64'(bus.DumpIndex), 64'd0);
        tick();
        wait_done("restart_done_seen");

        // Randomized traffic with dumps and backpressure
        for (int c = 0; c < 1500; c++) begin
            bus.RegWrite      = 1'($urandom_range(0, 1));
            bus.WriteRegister = 5'($urandom);
            bus.WriteData     = $urandom;
            bus.ReadRegister1 = ($urandom_range(0, 3) == 0) ? bus.WriteRegister : 5'($urandom);
            bus.ReadRegister2 = ($urandom_range(0, 3) == 0) ? bus.WriteRegister : 5'($urandom);
            bus.DumpStart     = ($urandom_range(0, 19) == 0);
            bus.DumpReady     = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.RegWrite  = 1'b0;
        bus.DumpStart = 1'b0;
        bus.DumpReady = 1'b1;
        repeat (40) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'(bus.DumpValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
